data_mem_sized: RTL and testbench

- Parametrised data memory for the MIPS pipeline; successor to the single-cycle word-only DM.
- Word, halfword and byte loads and stores, with sign or zero extension on loads.
- Uses a valid/ready request port and a one-shot response with a configurable number of wait states.
- Sequential clear after reset; reports misaligned, out-of-range and illegal-size accesses through an error flag instead of performing them.

---
 rtl/data_mem_sized.sv | 139 +++++++++++++
 tb/tb_data_mem_sized.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sized.sv
// rtl/data_mem_sized.sv - sized load/store data memory with valid/ready request and timed one-shot response
module data_mem_sized #(
    parameter int ADDR_WIDTH     = 12,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} stateType;

    stateType state, nextState;

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic          weQ, signedQ, readyQ;
    logic [1:0]    sizeQ;
    logic [31:0]   addrQ, wdataQ, pcQ;
    logic [IW-1:0] idxQ;
    logic [2:0]    cntQ;

    logic          accept, accErr;
    logic [IW-1:0] wordIdx;
    logic [31:0]   curWord, merged, loadData;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;

    assign req_ready = readyQ;
    assign accept    = req_valid && readyQ;
    assign wordIdx   = addrQ[ADDR_WIDTH-1:2];
    assign curWord   = mem[wordIdx];

    always_comb begin
        nextState = state;
        case (state)
            CLEAR: if (idxQ == IW'(DEPTH - 1)) nextState = IDLE;
            IDLE:  if (accept) nextState = (LATENCY > 0) ? WAIT : RESP;
            WAIT:  if (cntQ == 3'd1) nextState = RESP;
            RESP:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Rejected accesses never touch the array; the upper-address test catches anything beyond the implemented range.
    always_comb begin
        accErr = (sizeQ == 2'b11)
              || (sizeQ == 2'b01 && addrQ[0])
              || (sizeQ == 2'b10 && addrQ[1:0] != 2'b00)
              || (addrQ[31:ADDR_WIDTH] != '0);
    end

    always_comb begin
        merged   = curWord;
        loadData = '0;
        byteSel  = curWord[{addrQ[1:0], 3'b000} +: 8];
        halfSel  = curWord[{addrQ[1], 4'b0000} +: 16];
        case (sizeQ)
            2'b00: begin
                merged[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
                loadData = {{24{signedQ & byteSel[7]}}, byteSel};
            end
            2'b01: begin
                merged[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
                loadData = {{16{signedQ & halfSel[15]}}, halfSel};
            end
            2'b10: begin
                merged   = wdataQ;
                loadData = curWord;
            end
            default: begin
                merged   = curWord;
                loadData = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idxQ       <= '0;
            cntQ       <= '0;
            readyQ     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            readyQ     <= (nextState == IDLE);
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                CLEAR: begin
                    mem[idxQ] <= '0;
                    idxQ      <= idxQ + 1'b1;
                end
                IDLE: begin
                    if (accept) begin
                        weQ     <= req_we;
                        sizeQ   <= req_size;
                        signedQ <= req_signed;
                        addrQ   <= req_addr;
                        wdataQ  <= req_wdata;
                        pcQ     <= req_pc;
                        cntQ    <= 3'(LATENCY);
                    end
                end
                WAIT: cntQ <= cntQ - 1'b1;
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= accErr;
                    resp_rdata <= (accErr || weQ) ? 32'd0 : loadData;
                    if (!accErr && weQ) begin
                        mem[wordIdx] <= merged;
                        $display("%d@%h: *%h <= %h", $time, pcQ, {addrQ[31:2], 2'b00}, merged);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_sized.sv
// tb/tb_data_mem_sized.sv - randomized and directed checks of data_mem_sized against a word-array model
module tb_data_mem_sized;
    logic        clk = 1'b0;
    logic        resetN    [3];
    logic        reqValid  [3];
    logic        reqReady  [3];
    logic        reqWe     [3];
    logic [1:0]  reqSize   [3];
    logic        reqSigned [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic [31:0] reqPc     [3];
    logic        respValid [3];
    logic [31:0] respRdata [3];
    logic        respErr   [3];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit [31:0] model [3][1024];
    int respCyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (respValid[2]) respCyc.push_back(cyc);

    // Instance 0: LATENCY 1, instance 1: LATENCY 3, instance 2: LATENCY 0.
    for (genvar g = 0; g < 3; g++) begin : gDut
        data_mem_sized #(
            .ADDR_WIDTH(12),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 0)),
            .CLEAR_ON_RESET(1)
        ) dut (
            .clk(clk), .reset(resetN[g]),
            .req_valid(reqValid[g]), .req_ready(reqReady[g]),
            .req_we(reqWe[g]), .req_size(reqSize[g]), .req_signed(reqSigned[g]),
            .req_addr(reqAddr[g]), .req_wdata(reqWdata[g]), .req_pc(reqPc[g]),
            .resp_valid(respValid[g]), .resp_rdata(respRdata[g]), .resp_err(respErr[g])
        );
    end

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a plain array of words updated with mask/shift arithmetic.
    task automatic modelAccess(input int g, input bit we, input bit [1:0] size, input bit sgn,
                               input bit [31:0] addr, input bit [31:0] wdata,
                               output bit [31:0] rdata, output bit err);
        bit [31:0] mask, v;
        int shift, idx;
        err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0) || (addr >= 4096);
        rdata = 0;
        if (err) return;
        idx   = addr / 4;
        mask  = (size == 0) ? 32'hFF : ((size == 1) ? 32'hFFFF : 32'hFFFF_FFFF);
        shift = (size == 2) ? 0 : 8 * ((size == 1) ? (addr % 4) / 2 * 2 : addr % 4);
        if (we) begin
            model[g][idx] = (model[g][idx] & ~(mask << shift)) | ((wdata & mask) << shift);
        end else begin
            v = (model[g][idx] >> shift) & mask;
            if (sgn && size != 2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
            rdata = v;
        end
    endtask

    task automatic doAccess(input int g, input bit we, input bit [1:0] size, input bit sgn,
                            input bit [31:0] addr, input bit [31:0] wdata, input string tag,
                            output bit [31:0] rdata, output bit err);
        int n;
        @(negedge clk);
        reqValid[g] = 1; reqWe[g] = we; reqSize[g] = size; reqSigned[g] = sgn;
        reqAddr[g] = addr; reqWdata[g] = wdata; reqPc[g] = $urandom;
        n = 0;
        while (!reqReady[g] && n < 3000) begin @(negedge clk); n++; end
        checkVal({tag, "_ready_timeout"}, 32'(n >= 3000), 0);
        @(negedge clk);
        reqValid[g] = 0; reqWe[g] = 1; reqSize[g] = 2'($urandom); reqAddr[g] = $urandom; reqWdata[g] = $urandom;
        n = 0;
        while (!respValid[g] && n < 20) begin @(negedge clk); n++; end
        checkVal({tag, "_latency"}, n, latOf(g) + 1);
        rdata = respRdata[g];
        err   = respErr[g];
        @(negedge clk);
        checkVal({tag, "_pulse"}, 32'(respValid[g]), 0);
        reqWe[g] = 0;
    endtask

    task automatic runCheck(input int g, input bit we, input bit [1:0] size, input bit sgn,
                            input bit [31:0] addr, input bit [31:0] wdata, input string tag);
        bit [31:0] got, exp;
        bit gotErr, expErr;
        doAccess(g, we, size, sgn, addr, wdata, tag, got, gotErr);
        modelAccess(g, we, size, sgn, addr, wdata, exp, expErr);
        checkVal({tag, "_rdata"}, got, exp);
        checkVal({tag, "_err"}, 32'(gotErr), 32'(expErr));
    endtask

    initial begin
        int n, seen;
        bit [31:0] got;
        bit gotErr;
        for (int g = 0; g < 3; g++) begin
            resetN[g] = 0; reqValid[g] = 0; reqWe[g] = 0; reqSize[g] = 0; reqSigned[g] = 0;
            reqAddr[g] = 0; reqWdata[g] = 0; reqPc[g] = 0;
            for (int i = 0; i < 1024; i++) model[g][i] = 0;
        end
        repeat (2) @(negedge clk);
        checkVal("reset_ready", 32'(reqReady[0]), 0);
        checkVal("reset_resp_valid", 32'(respValid[0]), 0);
        for (int g = 0; g < 3; g++) resetN[g] = 1;

        n = 0;
        while (!reqReady[0] && n < 3000) begin @(negedge clk); n++; end
        checkVal("clear_cycles", n, 1024);
        n = 0;
        while ((!reqReady[1] || !reqReady[2]) && n < 3000) begin @(negedge clk); n++; end
        checkVal("clear_others_timeout", 32'(n >= 3000), 0);

        runCheck(0, 0, 2, 0, 32'h3FC, 0, "clear_word_3fc");
        doAccess(0, 0, 2, 0, 32'h3FC, 0, "clear_word_3fc_const", got, gotErr);
        checkVal("clear_word_3fc_const_val", got, 32'h0);

        runCheck(0, 1, 2, 0, 32'h10, 32'h12345678, "st_word_10");
        doAccess(0, 0, 2, 0, 32'h10, 0, "ld_word_10", got, gotErr);
        checkVal("ld_word_10_val", got, 32'h12345678);
        runCheck(0, 1, 0, 0, 32'h11, 32'h000000AB, "st_byte_11");
        runCheck(0, 1, 1, 0, 32'h12, 32'h0000BEEF, "st_half_12");
        doAccess(0, 0, 2, 0, 32'h10, 0, "ld_merged_10", got, gotErr);
        checkVal("ld_merged_10_val", got, 32'hBEEFAB78);
        doAccess(0, 0, 0, 1, 32'h11, 0, "ld_byte_s", got, gotErr);
        checkVal("ld_byte_s_val", got, 32'hFFFFFFAB);
        doAccess(0, 0, 0, 0, 32'h11, 0, "ld_byte_u", got, gotErr);
        checkVal("ld_byte_u_val", got, 32'h000000AB);
        doAccess(0, 0, 1, 1, 32'h12, 0, "ld_half_s", got, gotErr);
        checkVal("ld_half_s_val", got, 32'hFFFFBEEF);

        doAccess(0, 1, 2, 0, 32'h22, 32'hDEADBEEF, "err_word_22", got, gotErr);
        checkVal("err_word_22_flag", 32'(gotErr), 1);
        checkVal("err_word_22_rdata", got, 0);
        doAccess(0, 0, 1, 1, 32'h13, 0, "err_half_13", got, gotErr);
        checkVal("err_half_13_flag", 32'(gotErr), 1);
        checkVal("err_half_13_rdata", got, 0);
        doAccess(0, 0, 3, 0, 32'h10, 0, "err_size3", got, gotErr);
        checkVal("err_size3_flag", 32'(gotErr), 1);
        checkVal("err_size3_rdata", got, 0);
        doAccess(0, 1, 2, 0, 32'h1000, 32'hCAFEF00D, "err_range", got, gotErr);
        checkVal("err_range_flag", 32'(gotErr), 1);
        checkVal("err_range_rdata", got, 0);
        doAccess(0, 0, 2, 0, 32'h20, 0, "err_word_20", got, gotErr);
        checkVal("err_word_20_val", got, 0);
        doAccess(0, 0, 2, 0, 32'h0, 0, "err_word_00", got, gotErr);
        checkVal("err_word_00_val", got, 0);

        for (int i = 0; i < 300; i++) begin
            bit we, sgn;
            bit [1:0] size;
            bit [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       addr = 32'h1000 + $urandom_range(0, 255);
                1:       addr = 32'hFF0 + $urandom_range(0, 15);
                default: addr = $urandom_range(0, 'h7F);
            endcase
            runCheck(0, we, size, sgn, addr, $urandom, $sformatf("rand%0d", i));
        end
        for (int i = 0; i < 32; i++) runCheck(0, 0, 2, 0, 32'(4 * i), 0, $sformatf("sweep%0d", i));

        @(negedge clk);
        reqValid[1] = 1; reqWe[1] = 1; reqSize[1] = 2; reqAddr[1] = 32'h40; reqWdata[1] = 32'hFFFFFFFF;
        n = 0;
        while (!reqReady[1] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        reqValid[1] = 0;
        @(negedge clk);
        resetN[1] = 0;
        @(negedge clk);
        resetN[1] = 1;
        n = 0; seen = 0;
        while (!reqReady[1] && n < 3000) begin
            if (respValid[1]) seen++;
            @(negedge clk); n++;
        end
        checkVal("midreset_no_resp", seen, 0);
        checkVal("midreset_clear_timeout", 32'(n >= 3000), 0);
        doAccess(1, 0, 2, 0, 32'h40, 0, "midreset_word_40", got, gotErr);
        checkVal("midreset_word_40_val", got, 0);

        respCyc.delete();
        for (int i = 0; i < 4; i++) begin
            bit [31:0] d, e;
            bit ee;
            d = $urandom;
            @(negedge clk);
            reqValid[2] = 1; reqWe[2] = 1; reqSize[2] = 2; reqAddr[2] = 32'(4 * i); reqWdata[2] = d;
            n = 0;
            while (!reqReady[2] && n < 20) begin @(negedge clk); n++; end
            checkVal($sformatf("b2b_ready%0d", i), 32'(n >= 20), 0);
            modelAccess(2, 1, 2, 0, 32'(4 * i), d, e, ee);
        end
        @(negedge clk);
        reqValid[2] = 0; reqWe[2] = 0;
        repeat (4) @(negedge clk);
        checkVal("b2b_resp_count", respCyc.size(), 4);
        for (int i = 1; i < respCyc.size(); i++)
            checkVal($sformatf("b2b_spacing%0d", i), respCyc[i] - respCyc[i-1], 2);
        for (int i = 0; i < 4; i++) runCheck(2, 0, 2, 0, 32'(4 * i), 0, $sformatf("b2b_rd%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
